reg_bank_rw: RTL and testbench

Parametrised single-port register bank. It extends the single 16-bit read/write data register to DEPTH addressable words of DATA_W bits, adding byte-enabled writes, a registered read with valid strobe, out-of-range detection and a self-timed bulk clear sequence. It sits on the local datapath as scratch storage for a controller that issues one request per cycle.

---
 rtl/reg_bank_rw_if.sv | 29 ++
 rtl/reg_bank_rw.sv | 82 ++++++++
 tb/tb_reg_bank_rw.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_rw_if.sv
// Request/response bundle for the register bank: requester drives master side,
// the bank sits on the slave side.
interface reg_bank_rw_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic                  req;
  logic                  read_write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     in;
  logic [DATA_W/8-1:0]   be;
  logic                  clear;
  logic [DATA_W-1:0]     out;
  logic                  out_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output req, read_write, addr, in, be, clear,
    input  out, out_valid, busy, err
  );

  modport slave (
    input  req, read_write, addr, in, be, clear,
    output out, out_valid, busy, err
  );
endinterface

// File: rtl/reg_bank_rw.sv
// Single-port scratch register bank: byte-enabled writes, registered reads,
// out-of-range rejection and a self-timed sweep that zeroes every word.
module reg_bank_rw #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic         clk,
  input  logic         reset,
  reg_bank_rw_if.slave bus
);
  localparam int ADDR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              ptr_q, ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]   mem_q;
  logic [DATA_W-1:0]              out_q, rd_word, wr_word;
  logic                           out_valid_q, err_q;
  logic                           in_range, acc_rd, acc_wr, rej;

  // Extra bit so DEPTH itself is representable when DEPTH is a power of two.
  assign in_range = ({1'b0, bus.addr} < (ADDR_W+1)'(DEPTH));
  assign rd_word  = in_range ? mem_q[bus.addr] : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign wr_word[8*g +: 8] = bus.be[g] ? bus.in[8*g +: 8] : rd_word[8*g +: 8];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    rej     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
          rej     = bus.req;
        end else if (bus.req) begin
          if (!in_range)          rej    = 1'b1;
          else if (bus.read_write) acc_wr = 1'b1;
          else                    acc_rd = 1'b1;
        end
      end
      CLEAR: begin
        // clear is deliberately ignored here: the sweep never restarts.
        rej = bus.req;
        if (ptr_q == ADDR_W'(DEPTH-1)) state_d = IDLE;
        else                           ptr_d   = ptr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      mem_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= acc_rd;
      err_q       <= rej;
      if (acc_rd)            out_q          <= rd_word;
      if (acc_wr)            mem_q[bus.addr] <= wr_word;
      if (state_q == CLEAR)  mem_q[ptr_q]   <= '0;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == CLEAR);
endmodule

// File: tb/tb_reg_bank_rw.sv
// Bench for reg_bank_rw: directed scenarios plus a cycle-accurate model whose
// per-cycle predictions are queued and compared by a monitor process.
module tb_reg_bank_rw;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_bank_rw_if #(.DATA_W(16), .DEPTH(8)) if8 ();
  reg_bank_rw_if #(.DATA_W(16), .DEPTH(6)) if6 ();

  reg_bank_rw #(.DATA_W(16), .DEPTH(8)) u8 (.clk(clk), .reset(reset), .bus(if8.slave));
  reg_bank_rw #(.DATA_W(16), .DEPTH(6)) u6 (.clk(clk), .reset(reset), .bus(if6.slave));

  typedef struct packed {
    logic [15:0] out;
    logic        ov;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // reference model of the DEPTH=8 instance
  logic [15:0] m_mem [8];
  logic [15:0] m_out;
  logic        m_ov, m_err, m_clr;
  int          m_ptr;

  task automatic model_step();
    logic rej;
    rej = 1'b0;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
      m_out = 16'h0; m_ov = 1'b0; m_clr = 1'b0; m_ptr = 0;
    end else begin
      m_ov = 1'b0;
      if (m_clr) begin
        rej = if8.req;
        m_mem[m_ptr] = 16'h0;
        if (m_ptr == 7) m_clr = 1'b0;
        else            m_ptr = m_ptr + 1;
      end else if (if8.clear) begin
        rej = if8.req; m_clr = 1'b1; m_ptr = 0;
      end else if (if8.req) begin
        if (if8.read_write) begin
          if (if8.be[0]) m_mem[if8.addr][7:0]  = if8.in[7:0];
          if (if8.be[1]) m_mem[if8.addr][15:8] = if8.in[15:8];
        end else begin
          m_out = m_mem[if8.addr]; m_ov = 1'b1;
        end
      end
    end
    m_err = reset ? 1'b0 : rej;
    sb.push_back('{out: m_out, ov: m_ov, busy: m_clr, err: m_err});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e, a;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{out: if8.out, ov: if8.out_valid, busy: if8.busy, err: if8.err};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard @%0t: got out=%h ov=%b busy=%b err=%b expected out=%h ov=%b busy=%b err=%b",
                 $time, a.out, a.ov, a.busy, a.err, e.out, e.ov, e.busy, e.err);
      end
    end
  end

  task automatic idle8();
    if8.req = 1'b0; if8.read_write = 1'b0; if8.clear = 1'b0;
  endtask

  task automatic wr8(input int a, input logic [15:0] d, input logic [1:0] be);
    if8.req = 1'b1; if8.read_write = 1'b1; if8.addr = 3'(a); if8.in = d; if8.be = be;
    tick();
  endtask

  task automatic rd8(input int a);
    if8.req = 1'b1; if8.read_write = 1'b0; if8.addr = 3'(a);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle8(); if8.addr = '0; if8.in = '0; if8.be = '0;
    if6.req = 1'b0; if6.read_write = 1'b0; if6.addr = '0; if6.in = '0; if6.be = '0; if6.clear = 1'b0;
    tick(); tick();
    checks++;
    if ({if8.out, if8.out_valid, if8.busy, if8.err} !== 19'h0) begin
      errors++; $display("FAIL reset8: got %h expected 0", {if8.out, if8.out_valid, if8.busy, if8.err});
    end
    checks++;
    if ({if6.out, if6.out_valid, if6.busy, if6.err} !== 19'h0) begin
      errors++; $display("FAIL reset6: got %h expected 0", {if6.out, if6.out_valid, if6.busy, if6.err});
    end
    reset = 1'b0;
  endtask

  task automatic test_fill_readback();
    for (int a = 0; a < 8; a++) wr8(a, 16'h1000 + 16'(a), 2'b11);
    for (int a = 0; a < 8; a++) begin
      rd8(a);
      checks++;
      if (if8.out !== 16'h1000 + 16'(a) || if8.out_valid !== 1'b1 || if8.err !== 1'b0) begin
        errors++;
        $display("FAIL readback[%0d]: got out=%h ov=%b err=%b expected out=%h ov=1 err=0",
                 a, if8.out, if8.out_valid, if8.err, 16'h1000 + 16'(a));
      end
    end
    idle8(); tick();
  endtask

  task automatic test_byte_enable();
    wr8(3, 16'hABCD, 2'b11);
    wr8(3, 16'h1234, 2'b01);
    rd8(3);
    checks++;
    if (if8.out !== 16'hAB34) begin
      errors++; $display("FAIL be_low: got %h expected ab34", if8.out);
    end
    wr8(3, 16'h1234, 2'b00);
    checks++;
    if (if8.err !== 1'b0) begin
      errors++; $display("FAIL be_zero_err: got %b expected 0", if8.err);
    end
    rd8(3);
    checks++;
    if (if8.out !== 16'hAB34) begin
      errors++; $display("FAIL be_zero: got %h expected ab34", if8.out);
    end
    idle8(); tick();
  endtask

  task automatic test_clear_contention();
    int busy_cycles;
    for (int a = 0; a < 8; a++) if (a != 3) wr8(a, 16'h3000 + 16'(a), 2'b11);
    idle8(); tick();
    busy_cycles = 0;
    if8.clear = 1'b1; if8.req = 1'b1; if8.read_write = 1'b0; if8.addr = 3'd1;
    tick();
    if8.clear = 1'b0;
    if (if8.busy === 1'b1) busy_cycles++;
    checks++;
    if (if8.err !== 1'b1) begin
      errors++; $display("FAIL clear_same_cycle_err: got %b expected 1", if8.err);
    end
    for (int k = 0; k < 8; k++) begin
      if8.clear = (k == 3);
      rd8(k);
      if (if8.busy === 1'b1) busy_cycles++;
      checks++;
      if (if8.err !== 1'b1 || if8.out_valid !== 1'b0 || if8.out !== 16'hAB34) begin
        errors++;
        $display("FAIL sweep_read[%0d]: got err=%b ov=%b out=%h expected err=1 ov=0 out=ab34",
                 k, if8.err, if8.out_valid, if8.out);
      end
    end
    if8.clear = 1'b0;
    checks++;
    if (busy_cycles != 8) begin
      errors++; $display("FAIL busy_len: got %0d expected 8", busy_cycles);
    end
    for (int a = 0; a < 8; a++) begin
      rd8(a);
      checks++;
      if (if8.out !== 16'h0000 || if8.out_valid !== 1'b1) begin
        errors++; $display("FAIL cleared[%0d]: got out=%h ov=%b expected 0000 ov=1", a, if8.out, if8.out_valid);
      end
    end
    idle8(); tick();
  endtask

  task automatic test_out_of_range();
    for (int a = 0; a < 6; a++) begin
      if6.req = 1'b1; if6.read_write = 1'b1; if6.addr = 3'(a); if6.in = 16'h2000 + 16'(a); if6.be = 2'b11;
      tick();
    end
    if6.addr = 3'd6; if6.in = 16'hFFFF;
    tick();
    checks++;
    if (if6.err !== 1'b1 || if6.out_valid !== 1'b0) begin
      errors++; $display("FAIL oor_write: got err=%b ov=%b expected err=1 ov=0", if6.err, if6.out_valid);
    end
    if6.read_write = 1'b0; if6.addr = 3'd7;
    tick();
    checks++;
    if (if6.err !== 1'b1 || if6.out_valid !== 1'b0 || if6.out !== 16'h0000) begin
      errors++; $display("FAIL oor_read: got err=%b ov=%b out=%h expected err=1 ov=0 out=0000",
                         if6.err, if6.out_valid, if6.out);
    end
    for (int a = 0; a < 6; a++) begin
      if6.addr = 3'(a);
      tick();
      checks++;
      if (if6.out !== 16'h2000 + 16'(a) || if6.out_valid !== 1'b1 || if6.err !== 1'b0) begin
        errors++; $display("FAIL oor_keep[%0d]: got out=%h ov=%b err=%b expected %h ov=1 err=0",
                           a, if6.out, if6.out_valid, if6.err, 16'h2000 + 16'(a));
      end
    end
    if6.req = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    wr8(2, 16'h55AA, 2'b11);
    idle8(); if8.clear = 1'b1; tick();
    if8.clear = 1'b0; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (if8.busy !== 1'b0 || if8.out !== 16'h0 || if8.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_sweep: got busy=%b out=%h ov=%b expected 0", if8.busy, if8.out, if8.out_valid);
    end
    rd8(2);
    checks++;
    if (if8.out !== 16'h0000 || if8.out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_sweep_read: got %h expected 0000", if8.out);
    end
    wr8(5, 16'h1111, 2'b11);
    rd8(5);
    checks++;
    if (if8.out !== 16'h1111) begin
      errors++; $display("FAIL pre_reset_read: got %h expected 1111", if8.out);
    end
    idle8(); reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (if8.out !== 16'h0 || if8.out_valid !== 1'b0 || if8.busy !== 1'b0) begin
      errors++; $display("FAIL reset_after_read: got out=%h ov=%b busy=%b expected 0", if8.out, if8.out_valid, if8.busy);
    end
    rd8(5);
    checks++;
    if (if8.out !== 16'h0000) begin
      errors++; $display("FAIL reset_read5: got %h expected 0000", if8.out);
    end
    idle8(); tick();
  endtask

  task automatic test_random_soak();
    for (int c = 0; c < 1000; c++) begin
      if8.req        = 1'($urandom_range(0, 1));
      if8.read_write = 1'($urandom_range(0, 1));
      if8.addr       = 3'($urandom_range(0, 7));
      if8.be         = 2'($urandom_range(0, 3));
      if8.in         = 16'($urandom);
      if8.clear      = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle8(); tick();
  endtask

  initial begin
    test_reset();
    test_fill_readback();
    test_byte_enable();
    test_clear_contention();
    test_out_of_range();
    test_reset_mid();
    test_random_soak();
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
